// File: rtl/wb_write_buffer.sv
// Write-back buffer: in-order FIFO of completed results feeding the register file write port.
// Latency 1 cycle from accept to rf_we; in_ready drops when full. Optional commit trace under WB_TRACE_EN.
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_pc,
    input  logic             drain_en,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      rf_pc,
    input  logic [4:0]       fwd_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic [PTR_W:0]   wb_count
);

    localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [31:0]      r_rf_wdata;
    logic [31:0]      r_rf_pc;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_eff_addr;
    logic             w_fwd_hit;
    logic [31:0]      w_fwd_data;

    assign w_ready    = reset && (r_count != LP_FULL);
    assign w_eff_addr = (in_kind == 2'b10) ? 5'd31 : in_rd;
    // No-write kinds and r0 destinations are handshaken but never occupy a slot.
    assign w_push     = in_valid && w_ready && (in_kind != 2'b00) && (w_eff_addr != 5'd0);
    assign w_pop      = drain_en && (r_count != '0);

    assign in_ready = w_ready;
    assign wb_count = r_count;
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign rf_pc    = r_rf_pc;
    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= w_eff_addr;
            r_data[r_wr_ptr] <= in_data;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_pc    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= r_addr[r_rd_ptr];
                r_rf_wdata <= r_data[r_rd_ptr];
                r_rf_pc    <= r_pc[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
`ifdef WB_TRACE_EN
                $display("@%h: $%d <= %h", r_pc[r_rd_ptr], r_addr[r_rd_ptr], r_data[r_rd_ptr]);
`endif
            end else begin
                r_rf_we <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Lowest priority first (output register, then oldest queued) so the youngest match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (fwd_addr != 5'd0) begin
            if (r_rf_we && (r_rf_waddr == fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_rf_wdata;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (((PTR_W+1)'(k) < r_count) &&
                    (r_addr[r_rd_ptr + PTR_W'(k)] == fwd_addr)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_data[r_rd_ptr + PTR_W'(k)];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Randomized and directed bench for wb_write_buffer with a queue-based reference model and commit scoreboard.
module tb_wb_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic        drain_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_pc;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  wb_count;

    always #5 clock = ~clock;

    wb_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_data(in_data), .in_pc(in_pc),
        .drain_en(drain_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .wb_count(wb_count)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t mq[$];
    ent_t exp_q[$];
    ent_t m_rf = '0;
    bit   m_we = 1'b0;
    bit   m_acc = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a plain queue; a commit moves its front into the output register.
    always @(posedge clock) begin
        bit         rdy;
        logic [4:0] ea;
        rdy   = reset && (mq.size() != 4);
        m_acc = in_valid && rdy;
        if (!reset) begin
            mq.delete();
            m_we = 1'b0;
            m_rf = '0;
        end else begin
            if (drain_en && mq.size() != 0) begin
                m_rf = mq.pop_front();
                m_we = 1'b1;
                exp_q.push_back(m_rf);
            end else begin
                m_we = 1'b0;
            end
            if (m_acc && in_kind != 2'b00) begin
                ea = (in_kind == 2'b10) ? 5'd31 : in_rd;
                if (ea != 5'd0) mq.push_back('{ea, in_data, in_pc});
            end
        end
    end

    // Monitor: every cycle rf_we is high one scoreboard entry must be retired.
    always @(negedge clock) begin
        ent_t       e;
        bit         hit;
        logic [31:0] dat;
        if (chk_en) begin
            check("rf_we", {31'b0, rf_we}, {31'b0, m_we});
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got addr %h data %h, none pending", rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_addr", {27'b0, rf_waddr}, {27'b0, e.a});
                    check("commit_data", rf_wdata, e.d);
                    check("commit_pc", rf_pc, e.p);
                end
            end else begin
                check("rf_waddr_hold", {27'b0, rf_waddr}, {27'b0, m_rf.a});
                check("rf_wdata_hold", rf_wdata, m_rf.d);
                check("rf_pc_hold", rf_pc, m_rf.p);
            end
            check("wb_count", {29'b0, wb_count}, mq.size());
            check("in_ready", {31'b0, in_ready}, {31'b0, (reset === 1'b1) && (mq.size() != 4)});
            hit = 1'b0;
            dat = '0;
            if (fwd_addr != 5'd0) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (!hit && mq[i].a == fwd_addr) begin
                        hit = 1'b1;
                        dat = mq[i].d;
                    end
                end
                if (!hit && m_we && m_rf.a == fwd_addr) begin
                    hit = 1'b1;
                    dat = m_rf.d;
                end
            end
            check("fwd_hit", {31'b0, fwd_hit}, {31'b0, hit});
            check("fwd_data", fwd_data, dat);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        int n;
        in_valid = 1'b1;
        in_kind  = k;
        in_rd    = rd;
        in_data  = d;
        in_pc    = pc;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_acc && n < 20);
        if (!m_acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got no accept after %0d cycles, expected accept", n);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_kind  = 2'b00;
        in_rd    = '0;
        in_data  = '0;
        in_pc    = '0;
        drain_en = 1'b0;
        fwd_addr = '0;
        step();
        chk_en = 1'b1;
        check("reset_ready", {31'b0, in_ready}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Single push, then filtered kinds and r0.
        drain_en = 1'b1;
        fwd_addr = 5'd5;
        push(2'b01, 5'd5, 32'h0000_00AA, 32'h0000_3000);
        check("single_we", {31'b0, rf_we}, 32'd0);
        step();
        check("single_commit_addr", {27'b0, rf_waddr}, 32'd5);
        step();
        check("single_we_drop", {31'b0, rf_we}, 32'd0);
        push(2'b10, 5'd7, 32'h0000_3008, 32'h0000_3004);
        repeat (2) step();
        check("link_addr31", {27'b0, rf_waddr}, 32'd31);
        push(2'b01, 5'd0, 32'h1234, 32'h3010);
        check("r0_count", {29'b0, wb_count}, 32'd0);
        push(2'b00, 5'd9, 32'h5678, 32'h3014);
        check("kind00_count", {29'b0, wb_count}, 32'd0);
        repeat (2) step();

        // Fill with drain disabled, then hold a 5th offer.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b01, 5'(i + 1), 32'hA0 + i, 32'h4000 + 4 * i);
        check("full_count", {29'b0, wb_count}, 32'd4);
        check("full_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_kind  = 2'b11;
        in_rd    = 5'd12;
        in_data  = 32'hBEEF;
        in_pc    = 32'h4010;
        repeat (2) step();
        check("held_count", {29'b0, wb_count}, 32'd4);
        drain_en = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!m_acc && cyc < 10);
        in_valid = 1'b0;
        check("fifth_accept_cycle", cyc, 32'd2);
        repeat (6) step();

        // Forwarding: youngest of two writes to r3.
        drain_en = 1'b0;
        push(2'b01, 5'd3, 32'h11, 32'h5000);
        push(2'b01, 5'd3, 32'h22, 32'h5004);
        fwd_addr = 5'd3;
        #1;
        check("fwd3_hit", {31'b0, fwd_hit}, 32'd1);
        check("fwd3_data", fwd_data, 32'h22);
        fwd_addr = 5'd4;
        #1;
        check("fwd4_hit", {31'b0, fwd_hit}, 32'd0);
        fwd_addr = 5'd0;
        #1;
        check("fwd0_hit", {31'b0, fwd_hit}, 32'd0);
        check("fwd0_data", fwd_data, 32'd0);
        drain_en = 1'b1;
        repeat (4) step();

        // Streaming with simultaneous push/pop across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            fwd_addr = 5'(i);
            push(2'b01, 5'(i), 32'(i) * 32'h100, 32'h6000 + 4 * i);
            check("stream_ready", {31'b0, in_ready}, 32'd1);
            check("stream_count_le1", {31'b0, wb_count <= 3'd1}, 32'd1);
        end
        repeat (3) step();

        // Reset mid-drain.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) push(2'b01, 5'(20 + i), 32'hC0 + i, 32'h7000 + 4 * i);
        drain_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rst_count", {29'b0, wb_count}, 32'd0);
        check("rst_we", {31'b0, rf_we}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        reset = 1'b1;
        repeat (4) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_kind  = 2'($urandom_range(0, 3));
            in_rd    = 5'($urandom_range(0, 31));
            in_data  = $urandom;
            in_pc    = $urandom;
            drain_en = ($urandom_range(0, 2) != 0);
            fwd_addr = 5'($urandom_range(0, 31));
            reset    = ($urandom_range(0, 99) != 0);
            step();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        drain_en = 1'b1;
        repeat (8) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("model_empty", {29'b0, wb_count}, 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
